// File: rtl/conv_image_feeder_pkg.sv
// Shared types and widths for the conv_pool image feeder.
package conv_feeder_pkg;
   localparam int PIX_W      = 8;
   localparam int IMG_DATA_W = 16 * PIX_W;
   localparam int IMG_ADDR_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SERVE = 2'd2
   } feeder_state_t;
endpackage

// File: rtl/conv_image_feeder_if.sv
// Host load channel and conv_pool read port of the image feeder, bundled as one interface.
interface conv_feeder_if import conv_feeder_pkg::*; #(
   parameter int DATA_W = IMG_DATA_W,
   parameter int ADDR_W = IMG_ADDR_W
);
   logic              load_start;
   logic [ADDR_W:0]   load_len;
   logic              ld_valid;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;
   logic              loaded;
   logic              run_start;
   logic              clear;
   logic              input_re;
   logic [ADDR_W-1:0] input_addr;
   logic [DATA_W-1:0] image_4x4;
   logic              oob_err;
   logic [31:0]       read_count;

   modport master (
      output load_start, load_len, ld_valid, ld_data, clear, input_re, input_addr,
      input  ld_ready, loaded, run_start, image_4x4, oob_err, read_count
   );

   modport slave (
      input  load_start, load_len, ld_valid, ld_data, clear, input_re, input_addr,
      output ld_ready, loaded, run_start, image_4x4, oob_err, read_count
   );
endinterface

// File: rtl/conv_image_feeder_ram.sv
// Simple dual-port image buffer: one write port, one registered read port, no reset on contents.
module conv_image_ram #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 65536
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
      if (re) rdata <= r_mem[raddr];
   end
endmodule

// File: rtl/conv_image_feeder.sv
// Image buffer responder for conv_pool: host loads words, then reads are served with 1-cycle latency.
// Optional serviced-read counter enabled by CONV_FEEDER_READ_CNT_EN.
//
// state | meaning
// IDLE  | waiting for an accepted load_start
// LOAD  | accepting host words into the buffer
// SERVE | buffer valid, answering conv_pool reads
module conv_image_feeder import conv_feeder_pkg::*; #(
   parameter int DATA_W = IMG_DATA_W,
   parameter int ADDR_W = IMG_ADDR_W,
   parameter int DEPTH  = 65536
) (
   input logic          clk,
   input logic          rst,
   conv_feeder_if.slave bus
);
   localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] WPTR_ONE = ADDR_W'(1);

   feeder_state_t     r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_wptr;
   logic [ADDR_W:0]   r_len_q;
   logic              r_run_start, r_rd_hit, r_oob_err;
   logic              w_load_acc, w_wr_beat, w_last_beat;
   logic              w_rd_req, w_rd_hit, w_rd_oob;
   logic [DATA_W-1:0] w_ram_q;

   assign w_load_acc  = (r_state == IDLE) && bus.load_start &&
                        (bus.load_len != '0) && (bus.load_len <= DEPTH_L);
   assign w_wr_beat   = (r_state == LOAD) && bus.ld_valid;
   assign w_last_beat = w_wr_beat && ({1'b0, r_wptr} == (r_len_q - LEN_ONE));
   assign w_rd_req    = (r_state == SERVE) && bus.input_re;
   assign w_rd_hit    = w_rd_req && ({1'b0, bus.input_addr} < r_len_q);
   assign w_rd_oob    = w_rd_req && !w_rd_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_load_acc)  w_state_nxt = LOAD;
         LOAD:    if (w_last_beat) w_state_nxt = SERVE;
         SERVE:   if (bus.clear)   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr      <= '0;
         r_len_q     <= '0;
         r_run_start <= 1'b0;
         r_rd_hit    <= 1'b0;
         r_oob_err   <= 1'b0;
      end else begin
         r_run_start <= w_last_beat;
         r_rd_hit    <= w_rd_hit;
         if (w_load_acc) begin
            r_len_q <= bus.load_len;
            r_wptr  <= '0;
         end else if (w_wr_beat) begin
            r_wptr  <= r_wptr + WPTR_ONE;
         end
         if (w_load_acc)    r_oob_err <= 1'b0;
         else if (w_rd_oob) r_oob_err <= 1'b1;
      end
   end

   // RAM only reads on an in-range request; r_rd_hit masks its unreset output to zero otherwise.
   conv_image_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (w_wr_beat),
      .waddr (r_wptr),
      .wdata (bus.ld_data),
      .re    (w_rd_hit),
      .raddr (bus.input_addr),
      .rdata (w_ram_q)
   );

   assign bus.ld_ready  = (r_state == LOAD);
   assign bus.loaded    = (r_state == SERVE);
   assign bus.run_start = r_run_start;
   assign bus.image_4x4 = r_rd_hit ? w_ram_q : '0;
   assign bus.oob_err   = r_oob_err;

`ifdef CONV_FEEDER_READ_CNT_EN
   logic [31:0] r_read_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_read_count <= '0;
      else if (w_load_acc)
         r_read_count <= '0;
      else if (w_rd_req && (r_read_count != 32'hFFFF_FFFF))
         r_read_count <= r_read_count + 32'd1;
   end

   assign bus.read_count = r_read_count;
`else
   assign bus.read_count = '0;
`endif
endmodule

// File: tb/tb_conv_image_feeder.sv
// Self-checking bench for conv_image_feeder: table-driven reads with a response queue plus load/reset sequences.
module tb_conv_image_feeder;
   import conv_feeder_pkg::*;

`ifdef CONV_FEEDER_READ_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct {
      logic         re;
      logic [15:0]  addr;
      logic [127:0] d;
      logic         oob;
   } rd_vec_t;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_tot;
   logic [127:0] exp_q [$];
   rd_vec_t vecs [12];

   conv_feeder_if #(.DATA_W(128), .ADDR_W(16)) bus ();

   conv_image_feeder #(.DATA_W(128), .ADDR_W(16), .DEPTH(65536)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %h, required %h", nm, act, exp);
      else             n_pass++;
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %b, required %b", nm, act, exp);
      else             n_pass++;
   endtask

   // One read cycle; the expected word is queued on drive and popped when the response is due.
   task automatic step(input logic re, input logic [15:0] addr, input logic [127:0] exp_d, input string nm);
      logic [127:0] e;
      bus.input_re   = re;
      bus.input_addr = addr;
      exp_q.push_back(exp_d);
      @(posedge clk); #1;
      bus.input_re = 1'b0;
      e = exp_q.pop_front();
      chkw(nm, bus.image_4x4, e);
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
   endtask

   task automatic do_load(input int len, input logic [127:0] base, input bit toggle,
                          input int exp_ready, input string nm);
      int beat, cyc, rdy;
      bus.load_start = 1'b1;
      bus.load_len   = 17'(len);
      @(posedge clk); #1;
      bus.load_start = 1'b0;
      chkb({nm, "_oob_clr"}, bus.oob_err, 1'b0);
      chkw({nm, "_cnt_clr"}, 128'(bus.read_count), 128'd0);
      beat = 0; cyc = 0; rdy = 0;
      while (beat < len && cyc < 200) begin
         bus.ld_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
         bus.ld_data  = base + 128'(beat);
         if (bus.ld_ready) rdy++;
         if (bus.ld_valid && bus.ld_ready) beat++;
         @(posedge clk); #1;
         cyc++;
      end
      bus.ld_valid = 1'b0;
      chkb({nm, "_done"}, (beat == len), 1'b1);
      chkw({nm, "_ready_cycles"}, 128'(rdy), 128'(exp_ready));
      chkb({nm, "_ready_low"}, bus.ld_ready, 1'b0);
      chkb({nm, "_run_start"}, bus.run_start, 1'b1);
      chkb({nm, "_loaded"}, bus.loaded, 1'b1);
   endtask

   initial begin
      n_pass = 0;
      n_tot  = 0;
      bus.load_start = 1'b0; bus.load_len = '0; bus.ld_valid = 1'b0; bus.ld_data = '0;
      bus.clear = 1'b0; bus.input_re = 1'b0; bus.input_addr = '0;

      vecs[0]  = '{1'b1, 16'd0, 128'd1, 1'b0};
      vecs[1]  = '{1'b1, 16'd1, 128'd2, 1'b0};
      vecs[2]  = '{1'b1, 16'd2, 128'd3, 1'b0};
      vecs[3]  = '{1'b1, 16'd3, 128'd4, 1'b0};
      vecs[4]  = '{1'b0, 16'd3, 128'd0, 1'b0};
      vecs[5]  = '{1'b1, 16'd3, 128'd4, 1'b0};
      vecs[6]  = '{1'b1, 16'd2, 128'd3, 1'b0};
      vecs[7]  = '{1'b1, 16'd1, 128'd2, 1'b0};
      vecs[8]  = '{1'b1, 16'd0, 128'd1, 1'b0};
      vecs[9]  = '{1'b1, 16'd0, 128'd1, 1'b0};
      vecs[10] = '{1'b1, 16'd4, 128'd0, 1'b1};
      vecs[11] = '{1'b0, 16'd0, 128'd0, 1'b1};

      rst = 1'b1;
      #2 rst = 1'b0;
      #2;
      chkb("rst_ld_ready", bus.ld_ready, 1'b0);
      chkb("rst_loaded", bus.loaded, 1'b0);
      chkb("rst_run_start", bus.run_start, 1'b0);
      chkw("rst_image", bus.image_4x4, 128'd0);
      chkb("rst_oob", bus.oob_err, 1'b0);
      chkw("rst_count", 128'(bus.read_count), 128'd0);
      #8 rst = 1'b1;
      idle_cycle();

      // Illegal lengths are ignored; reads in IDLE return zero and never flag oob.
      bus.load_start = 1'b1; bus.load_len = 17'd0;
      idle_cycle();
      chkb("len0_ignored", bus.ld_ready, 1'b0);
      bus.load_len = 17'd65537;
      idle_cycle();
      bus.load_start = 1'b0;
      chkb("len_over_ignored", bus.ld_ready, 1'b0);
      step(1'b1, 16'd5, 128'd0, "idle_read_zero");
      chkb("idle_read_no_oob", bus.oob_err, 1'b0);

      do_load(4, 128'd1, 1'b0, 4, "load4");
      step(1'b0, 16'd0, 128'd0, "serve_first_idle");
      chkb("run_start_once", bus.run_start, 1'b0);
      chkb("loaded_hold", bus.loaded, 1'b1);

      for (int i = 0; i < 12; i++) begin
         step(vecs[i].re, vecs[i].addr, vecs[i].d, $sformatf("rd_vec%0d", i));
         chkb($sformatf("oob_vec%0d", i), bus.oob_err, vecs[i].oob);
      end
      chkw("read_count10", 128'(bus.read_count), CNT_EN ? 128'd10 : 128'd0);

      // Read issued alongside clear is still answered; output returns to zero afterwards.
      bus.clear = 1'b1;
      bus.input_re = 1'b1; bus.input_addr = 16'd1;
      exp_q.push_back(128'd2);
      @(posedge clk); #1;
      bus.clear = 1'b0; bus.input_re = 1'b0;
      chkw("clear_read", bus.image_4x4, exp_q.pop_front());
      chkb("clear_loaded", bus.loaded, 1'b0);
      chkb("oob_through_clear", bus.oob_err, 1'b1);
      step(1'b0, 16'd0, 128'd0, "after_clear_zero");

      do_load(3, 128'h100, 1'b1, 5, "load3_toggle");
      step(1'b1, 16'd0, 128'h100, "tog_rd0");
      step(1'b1, 16'd1, 128'h101, "tog_rd1");
      step(1'b1, 16'd2, 128'h102, "tog_rd2");
      chkb("tog_no_oob", bus.oob_err, 1'b0);
      step(1'b1, 16'd3, 128'd0, "tog_rd3_oob");
      chkb("tog_oob", bus.oob_err, 1'b1);
      chkw("tog_read_count", 128'(bus.read_count), CNT_EN ? 128'd4 : 128'd0);

      // SERVE ignores load_start.
      bus.load_start = 1'b1; bus.load_len = 17'd2;
      idle_cycle();
      bus.load_start = 1'b0;
      chkb("serve_ignores_start", bus.loaded, 1'b1);

      bus.clear = 1'b1;
      idle_cycle();
      bus.clear = 1'b0;

      // Reset partway through a 4-word load.
      bus.load_start = 1'b1; bus.load_len = 17'd4;
      idle_cycle();
      bus.load_start = 1'b0;
      bus.ld_valid = 1'b1; bus.ld_data = 128'hAA;
      idle_cycle();
      bus.ld_data = 128'hBB;
      idle_cycle();
      chkb("midload_ready", bus.ld_ready, 1'b1);
      #2 rst = 1'b0;
      #1;
      chkb("arst_ld_ready", bus.ld_ready, 1'b0);
      chkb("arst_loaded", bus.loaded, 1'b0);
      chkb("arst_run_start", bus.run_start, 1'b0);
      chkw("arst_image", bus.image_4x4, 128'd0);
      chkb("arst_oob", bus.oob_err, 1'b0);
      chkw("arst_count", 128'(bus.read_count), 128'd0);
      bus.ld_valid = 1'b0;
      #1 rst = 1'b1;
      idle_cycle();

      do_load(4, 128'h200, 1'b0, 4, "reload4");
      for (int i = 0; i < 4; i++)
         step(1'b1, 16'(i), 128'h200 + 128'(i), $sformatf("reload_rd%0d", i));
      chkb("reload_no_oob", bus.oob_err, 1'b0);
      chkw("reload_count", 128'(bus.read_count), CNT_EN ? 128'd4 : 128'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
